// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch controller
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_ALIGN_MASK        = 32'hFFFF_FFFC;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller signal bundle; perf ports under FETCH_PERF_CNT_EN
interface fetch_ctrl_if;

  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        resume_i;
  logic [31:0] pc_i;
  logic        pc_we_o;
  logic [31:0] pc_next_o;
  logic        if_id_flush_o;
  logic        fetch_valid_o;
  logic        halted_o;
  logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, halt_i, resume_i, pc_i,
`ifdef FETCH_PERF_CNT_EN
    output fetch_cnt_o, stall_cnt_o,
`endif
    output pc_we_o, pc_next_o, if_id_flush_o, fetch_valid_o, halted_o, misalign_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, halt_i, resume_i, pc_i,
`ifdef FETCH_PERF_CNT_EN
    input  fetch_cnt_o, stall_cnt_o,
`endif
    input  pc_we_o, pc_next_o, if_id_flush_o, fetch_valid_o, halted_o, misalign_o
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - free-running fetch and stall event counters, wrap at 2^32
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencing controller (boot hold, redirect flush, halt)
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR     = DEFAULT_RESET_VECTOR,
  parameter int          BOOT_HOLD_CYCLES = 4,
  parameter int          FLUSH_CYCLES     = 1
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam logic [7:0] BOOT_LOAD  = 8'(BOOT_HOLD_CYCLES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  fetch_state_e r_state;
  logic [7:0]   r_boot_cnt;
  logic [1:0]   r_flush_cnt;
  logic         r_misalign;

  logic        w_pc_we;
  logic [31:0] w_pc_next;
  logic        w_flush;
  logic        w_fetch_valid;
  logic        w_halted;
  logic        w_stall_path;
  logic        w_window;
  logic [31:0] w_seq_pc;
  logic [31:0] w_redir_pc;

  assign w_window   = (r_flush_cnt != 2'd0);
  assign w_seq_pc   = bus.pc_i + 32'd4;
  assign w_redir_pc = align_pc(bus.redirect_pc_i);

  // Reset forces the boot-time outputs even before the first edge samples it.
  always_comb begin
    w_pc_we       = 1'b1;
    w_pc_next     = RESET_VECTOR;
    w_flush       = 1'b1;
    w_fetch_valid = 1'b0;
    w_halted      = 1'b0;
    w_stall_path  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        BOOT: ;
        RUN: begin
          if (bus.redirect_valid_i) begin
            w_pc_next = w_redir_pc;
          end else if (bus.halt_i) begin
            w_pc_we   = 1'b0;
            w_pc_next = w_seq_pc;
          end else if (bus.stall_i) begin
            w_pc_we      = 1'b0;
            w_pc_next    = w_seq_pc;
            w_flush      = w_window;
            w_stall_path = 1'b1;
          end else begin
            w_pc_next = w_seq_pc;
            w_flush   = w_window;
          end
          w_fetch_valid = !w_flush;
        end
        HALTED: begin
          w_halted  = 1'b1;
          w_pc_we   = bus.redirect_valid_i;
          w_pc_next = bus.redirect_valid_i ? w_redir_pc : w_seq_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_boot_cnt  <= BOOT_LOAD;
      r_flush_cnt <= 2'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (w_window) r_flush_cnt <= r_flush_cnt - 2'd1;
      unique case (r_state)
        BOOT: begin
          if (r_boot_cnt == 8'd0) r_state <= RUN;
          else                    r_boot_cnt <= r_boot_cnt - 8'd1;
        end
        RUN: begin
          if (bus.redirect_valid_i) begin
            r_flush_cnt <= FLUSH_LOAD;
            r_misalign  <= |bus.redirect_pc_i[1:0];
          end
          if (bus.halt_i) r_state <= HALTED;
        end
        HALTED: begin
          // Debug set-PC: redirect is applied but the core stays halted.
          if (bus.redirect_valid_i) r_misalign <= |bus.redirect_pc_i[1:0];
          if (bus.resume_i && !bus.halt_i) r_state <= RUN;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign bus.pc_we_o       = w_pc_we;
  assign bus.pc_next_o     = w_pc_next;
  assign bus.if_id_flush_o = w_flush;
  assign bus.fetch_valid_o = w_fetch_valid;
  assign bus.halted_o      = w_halted;
  assign bus.misalign_o    = r_misalign & ~rst;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_fetch_valid & w_pc_we),
    .i_stall_inc (w_stall_path),
    .o_fetch_cnt (bus.fetch_cnt_o),
    .o_stall_cnt (bus.stall_cnt_o)
  );
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Drives the program counter's write enable and next-PC value.
- Gates fetch validity into the IF/ID register and flushes IF/ID on redirects.
- Holds fetch off for a fixed boot window after reset; supports halt/resume from downstream. Sits between the hazard/branch logic and the IF stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000: first fetch address after boot.
- BOOT_HOLD_CYCLES, 4: cycles after reset release before fetch starts; legal range 1..255.
- FLUSH_CYCLES, 1: cycles if_id_flush_o stays high per redirect, counting the redirect cycle; legal range 1..3.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard unit hold request.
- redirect_valid_i  input  1  taken branch/jump from EX.
- redirect_pc_i  input  32  redirect target.
- halt_i  input  1  halt request (ebreak/debug).
- resume_i  input  1  leave halt.
- pc_i  input  32  current PC from the program counter.
- pc_we_o  output  1  program counter write enable.
- pc_next_o  output  32  value loaded into the PC when pc_we_o is high.
- if_id_flush_o  output  1  insert bubble into IF/ID.
- fetch_valid_o  output  1  IF output is a real instruction.
- halted_o  output  1  controller in HALTED.
- misalign_o  output  1  one-cycle pulse, misaligned redirect target seen.

Behaviour:
- Reset and synchronicity
  - Single clock domain; reset is synchronous and active-high.
  - While rst is high: state is BOOT, boot counter = BOOT_HOLD_CYCLES-1, flush counter = 0.
  - Outputs while rst is high: pc_we_o=1, pc_next_o=RESET_VECTOR, if_id_flush_o=1, fetch_valid_o=0, halted_o=0, misalign_o=0.
- States: BOOT, RUN, HALTED (enum). Outputs are combinational from state, counters and inputs; misalign_o is registered.
- BOOT
  - pc_we_o=1, pc_next_o=RESET_VECTOR, flush=1, fetch_valid_o=0. All inputs are ignored.
  - Counter decrements each cycle. At 0, the next state is RUN.
  - First real fetch of RESET_VECTOR happens exactly BOOT_HOLD_CYCLES cycles after rst deasserts.
- RUN, fixed priority: redirect > halt > stall > sequential.
  - Redirect:
    - pc_we_o=1, pc_next_o={redirect_pc_i[31:2],2'b00}, flush=1, fetch_valid_o=0.
    - Flush counter loads FLUSH_CYCLES-1.
    - If redirect_pc_i[1:0]!=0, misalign_o pulses the next cycle.
  - Halt:
    - pc_we_o=0, flush=1, fetch_valid_o=0; next state HALTED.
    - If a redirect occurs in the same cycle, the redirect is also applied and the state still goes to HALTED.
  - Stall: pc_we_o=0, flush=0, fetch_valid_o=1; the PC and instruction are held.
  - Sequential: pc_we_o=1, pc_next_o=pc_i+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Flush window:
    - if_id_flush_o = redirect this cycle OR flush counter != 0.
    - The flush counter decrements every cycle regardless of stall.
    - fetch_valid_o = !if_id_flush_o in RUN.
    - A new redirect inside the flush window reloads the counter.
- HALTED
  - halted_o=1, pc_we_o=0, flush=1, fetch_valid_o=0.
  - redirect_valid_i still loads the PC (debug set-PC); the state remains HALTED.
  - resume_i with !halt_i moves to RUN next cycle. If halt_i and resume_i are both high, halt wins.
  - stall_i is ignored.
- Reset in any state returns to BOOT on the next edge; any flush window or pending pulse is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both cleared by rst and wrapping at 2^32.
  - fetch_cnt_o counts cycles with fetch_valid_o && pc_we_o.
  - stall_cnt_o counts RUN cycles where the stall path is taken.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- core_pkg gains:
  - fetch_state_e {BOOT, RUN, HALTED};
  - localparam PC_ALIGN_MASK = 32'hFFFF_FFFC;
  - default RESET_VECTOR constant.
- One natural sub-module: fetch_perf_cnt (two counters), instantiated only under FETCH_PERF_CNT_EN.
- Next-PC selection stays inline.

Test Plan:
- Boot: rst high 3 cycles then low, BOOT_HOLD_CYCLES=4 -> fetch_valid_o=0 for 4 cycles; on the 5th cycle, pc_i=0, fetch_valid_o=1 and pc_next_o=32'h4.
- Sequential with stall: PC at 0x10, stall_i high 2 cycles -> pc_we_o=0 both cycles, fetch_valid_o=1; on release pc_next_o=0x14.
- Redirect with FLUSH_CYCLES=2, redirect_pc_i=0x103 while stall_i=1:
  - redirect wins: pc_next_o=0x100, pc_we_o=1;
  - flush high 2 cycles;
  - misalign_o pulses 1 cycle later.
- Halt and resume:
  - halt_i at PC 0x20 -> halted_o=1 next cycle and flush stays high.
  - redirect to 0x40 while halted -> PC becomes 0x40, still halted.
  - resume_i -> fetch resumes at 0x40.
- Wrap: pc_i=32'hFFFF_FFFC, no stall -> pc_next_o=0.
- Reset mid-flush: assert rst during a redirect flush window -> BOOT re-entered, pc_next_o=RESET_VECTOR, counters cleared (perf counts 0 under FETCH_PERF_CNT_EN).
